// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and opcode decode for the conv tile sequencer.
package cnn_pkg;

    localparam int unsigned BIT_W      = 8;
    localparam int unsigned KER_BYTES  = 72;
    localparam int unsigned IMG_BYTES  = 72;
    localparam int unsigned BIAS_BYTES = 2;
    localparam int unsigned OUT_BYTES  = 2;
    localparam int unsigned PE_LAT     = 3;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned OPCODE_W   = 4;
    localparam int unsigned OUT_ADDR_W = 4;
    localparam int unsigned TILE_W     = 9;
    localparam int unsigned BYTE_CNT_W = 7;
    localparam int unsigned EX_CNT_W   = 2;
    localparam int unsigned OUT_CNT_W  = 1;

    localparam logic [OPCODE_W-1:0] OP_CONV_1x32x32 = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_CONV_4x16x16 = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_CONV_8x8x8   = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_LINEAR       = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_KER  = 3'd1,
        ST_LD_BIAS = 3'd2,
        ST_LD_IMG  = 3'd3,
        ST_SWAP    = 3'd4,
        ST_EX      = 3'd5,
        ST_WB      = 3'd6,
        ST_DONE    = 3'd7
    } seq_state_e;

    // Only the four layer shapes below exist; anything above OP_LINEAR is rejected.
    function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
        return op <= OP_LINEAR;
    endfunction

    // Number of tiles a layer is split into.
    function automatic logic [TILE_W-1:0] tile_total(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_CONV_1x32x32: return TILE_W'(256);
            OP_CONV_4x16x16: return TILE_W'(64);
            OP_CONV_8x8x8:   return TILE_W'(16);
            OP_LINEAR:       return TILE_W'(1);
            default:         return TILE_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/seq_byte_counter.sv
// Loadable up-counter with enable, clear and a terminal-count compare.
module seq_byte_counter #(
    parameter int unsigned W = 7
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc_c
);

    // Clear wins over load, load wins over count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_load) begin
            o_cnt <= i_load_val;
        end else if (i_en) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

    assign o_tc_c = (o_cnt == i_term);

endmodule

// File: rtl/conv_tile_sequencer.sv
// Layer sequencer: loads kernel/bias once, then per tile loads image, swaps, executes, writes back.
module conv_tile_sequencer
    import cnn_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_trig,
    input  logic [OPCODE_W-1:0]   i_opcode,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_kernal_wd_en,
    output logic                  o_image_wd_en,
    output logic                  o_bias_wd_en,
    output logic [ADDR_W-1:0]     o_wd_addr,
    output logic                  o_buf_load,
    output logic                  o_out_wd_en,
    output logic [OUT_ADDR_W-1:0] o_out_addr,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    seq_state_e            state_q, state_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [TILE_W-1:0]     tile_cnt_q, tile_cnt_d;
    logic                  err_q, err_d;

    logic                  loading_c, xfer_c, in_ex_c, wb_take_c, last_tile_c;
    logic                  byte_tc_c, ex_tc_c, out_tc_c;
    logic [BYTE_CNT_W-1:0] byte_cnt, byte_term_c;
    logic [EX_CNT_W-1:0]   ex_cnt;
    logic [OUT_CNT_W-1:0]  out_cnt;

    assign loading_c   = (state_q == ST_LD_KER) || (state_q == ST_LD_BIAS) || (state_q == ST_LD_IMG);
    assign xfer_c      = loading_c && i_in_valid;
    assign in_ex_c     = (state_q == ST_EX);
    assign wb_take_c   = (state_q == ST_WB) && i_out_ready;
    assign last_tile_c = (tile_cnt_q == (tile_total(opcode_q) - TILE_W'(1)));

    // Last byte index of the stream currently being loaded.
    always_comb begin
        byte_term_c = BYTE_CNT_W'(IMG_BYTES - 1);
        case (state_q)
            ST_LD_KER:  byte_term_c = BYTE_CNT_W'(KER_BYTES - 1);
            ST_LD_BIAS: byte_term_c = BYTE_CNT_W'(BIAS_BYTES - 1);
            default:    ;
        endcase
    end

    // Byte index within the current load stream; returns to 0 on every load-state exit.
    seq_byte_counter #(.W(BYTE_CNT_W)) u_byte_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (xfer_c && byte_tc_c),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (xfer_c),
        .i_term     (byte_term_c),
        .o_cnt      (byte_cnt),
        .o_tc_c     (byte_tc_c)
    );

    // Fixed PE pipeline latency.
    seq_byte_counter #(.W(EX_CNT_W)) u_ex_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (in_ex_c && ex_tc_c),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (in_ex_c),
        .i_term     (EX_CNT_W'(PE_LAT - 1)),
        .o_cnt      (ex_cnt),
        .o_tc_c     (ex_tc_c)
    );

    // Output byte index; forced to 0 when the pool results are captured.
    seq_byte_counter #(.W(OUT_CNT_W)) u_out_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (wb_take_c && out_tc_c),
        .i_load     (in_ex_c && ex_tc_c),
        .i_load_val ('0),
        .i_en       (wb_take_c),
        .i_term     (OUT_CNT_W'(OUT_BYTES - 1)),
        .o_cnt      (out_cnt),
        .o_tc_c     (out_tc_c)
    );

    // State and layer context registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            tile_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            tile_cnt_q <= tile_cnt_d;
            err_q      <= err_d;
        end
    end

    assign o_err = err_q;

    // Next-state and datapath enables; write enables follow the host valid directly.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        tile_cnt_d     = tile_cnt_q;
        err_d          = 1'b0;
        o_in_ready     = 1'b0;
        o_kernal_wd_en = 1'b0;
        o_image_wd_en  = 1'b0;
        o_bias_wd_en   = 1'b0;
        o_wd_addr      = '0;
        o_buf_load     = 1'b0;
        o_out_wd_en    = 1'b0;
        o_out_addr     = '0;
        o_valid        = 1'b0;
        o_done         = 1'b0;
        o_busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (i_trig) begin
                    if (op_legal(i_opcode)) begin
                        state_d    = ST_LD_KER;
                        opcode_d   = i_opcode;
                        tile_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LD_KER: begin
                o_in_ready     = 1'b1;
                o_kernal_wd_en = i_in_valid;
                o_wd_addr      = ADDR_W'({byte_cnt, 3'b000});
                if (xfer_c && byte_tc_c) state_d = ST_LD_BIAS;
            end
            ST_LD_BIAS: begin
                o_in_ready   = 1'b1;
                o_bias_wd_en = i_in_valid;
                o_wd_addr    = ADDR_W'({byte_cnt, 3'b000});
                if (xfer_c && byte_tc_c) state_d = ST_LD_IMG;
            end
            ST_LD_IMG: begin
                o_in_ready    = 1'b1;
                o_image_wd_en = i_in_valid;
                o_wd_addr     = ADDR_W'({byte_cnt, 3'b000});
                if (xfer_c && byte_tc_c) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                o_buf_load = 1'b1;
                state_d    = ST_EX;
            end
            ST_EX: begin
                if (ex_tc_c) begin
                    o_out_wd_en = 1'b1;
                    state_d     = ST_WB;
                end
            end
            ST_WB: begin
                o_valid    = 1'b1;
                o_out_addr = OUT_ADDR_W'({out_cnt, 3'b000});
                if (wb_take_c && out_tc_c) begin
                    if (last_tile_c) begin
                        state_d = ST_DONE;
                    end else begin
                        tile_cnt_d = tile_cnt_q + TILE_W'(1);
                        state_d    = ST_LD_IMG;
                    end
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Scoreboard bench for conv_tile_sequencer: expected enable/address events are queued per layer.
module tb_conv_tile_sequencer;

    localparam logic [2:0] EV_K = 3'd0;
    localparam logic [2:0] EV_B = 3'd1;
    localparam logic [2:0] EV_I = 3'd2;
    localparam logic [2:0] EV_L = 3'd3;
    localparam logic [2:0] EV_W = 3'd4;
    localparam logic [2:0] EV_V = 3'd5;
    localparam logic [2:0] EV_D = 3'd6;
    localparam logic [2:0] EV_E = 3'd7;

    typedef struct packed {
        logic [2:0] kind;
        logic [9:0] addr;
    } ev_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_trig = 1'b0;
    logic [3:0] i_opcode = 4'd0;
    logic       i_in_valid = 1'b0;
    logic       i_out_ready = 1'b1;
    logic       o_in_ready, o_kernal_wd_en, o_image_wd_en, o_bias_wd_en;
    logic [9:0] o_wd_addr;
    logic       o_buf_load, o_out_wd_en;
    logic [3:0] o_out_addr;
    logic       o_valid, o_busy, o_done, o_err;

    wire [24:0] all_outs = {o_in_ready, o_kernal_wd_en, o_image_wd_en, o_bias_wd_en, o_wd_addr,
                            o_buf_load, o_out_wd_en, o_out_addr, o_valid, o_busy, o_done, o_err};

    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  c0 = 0;
    int  k_cnt = 0, i_cnt = 0, w_cnt = 0, d_cnt = 0, e_cnt = 0, l_cnt = 0;
    int  t_img0 = 0, t_load = 0, t_owd = 0, t_v0 = 0, t_done = 0, t_err = 0;
    logic toggle_valid = 1'b0;
    ev_t sb_q[$];

    conv_tile_sequencer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_trig         (i_trig),
        .i_opcode       (i_opcode),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .o_kernal_wd_en (o_kernal_wd_en),
        .o_image_wd_en  (o_image_wd_en),
        .o_bias_wd_en   (o_bias_wd_en),
        .o_wd_addr      (o_wd_addr),
        .o_buf_load     (o_buf_load),
        .o_out_wd_en    (o_out_wd_en),
        .o_out_addr     (o_out_addr),
        .o_valid        (o_valid),
        .i_out_ready    (i_out_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic sb_event(input logic [2:0] kind, input logic [9:0] addr);
        ev_t got, exp;
        got.kind = kind;
        got.addr = addr;
        if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'(got), 32'hFFFF_FFFF);
        end else begin
            exp = sb_q.pop_front();
            check("sb_event", 32'(got), 32'(exp));
        end
    endtask

    // Observe every enable/handshake away from the active edge.
    always @(negedge i_clk) begin
        if (o_kernal_wd_en) begin k_cnt++; sb_event(EV_K, o_wd_addr); end
        if (o_bias_wd_en) sb_event(EV_B, o_wd_addr);
        if (o_image_wd_en) begin
            if (o_wd_addr == 10'd0) t_img0 = cyc;
            i_cnt++;
            sb_event(EV_I, o_wd_addr);
        end
        if (o_buf_load) begin l_cnt++; t_load = cyc; sb_event(EV_L, 10'd0); end
        if (o_out_wd_en) begin w_cnt++; t_owd = cyc; sb_event(EV_W, 10'd0); end
        if (o_valid && i_out_ready) begin
            if (o_out_addr == 4'd0) t_v0 = cyc;
            sb_event(EV_V, 10'(o_out_addr));
        end
        if (o_done) begin d_cnt++; t_done = cyc; sb_event(EV_D, 10'd0); end
        if (o_err) begin e_cnt++; t_err = cyc; sb_event(EV_E, 10'd0); end
    end

    // Host byte valid: steady high, or alternating every cycle.
    initial forever begin
        @(posedge i_clk);
        #1;
        i_in_valid = toggle_valid ? ~i_in_valid : 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int tiles_of(input logic [3:0] op);
        case (op)
            4'd0:    return 256;
            4'd1:    return 64;
            4'd2:    return 16;
            4'd3:    return 1;
            default: return 0;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push_ev(input logic [2:0] kind, input logic [9:0] addr);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic push_head();
        for (int k = 0; k < 72; k++) push_ev(EV_K, 10'(k * 8));
        for (int k = 0; k < 2; k++) push_ev(EV_B, 10'(k * 8));
    endtask

    task automatic push_tile(input bit full);
        for (int k = 0; k < 72; k++) push_ev(EV_I, 10'(k * 8));
        push_ev(EV_L, 10'd0);
        if (full) begin
            push_ev(EV_W, 10'd0);
            push_ev(EV_V, 10'd0);
            push_ev(EV_V, 10'd8);
        end
    endtask

    task automatic push_layer(input logic [3:0] op);
        push_head();
        for (int t = 0; t < tiles_of(op); t++) push_tile(1'b1);
        push_ev(EV_D, 10'd0);
    endtask

    task automatic trig_op(input logic [3:0] op);
        i_trig   = 1'b1;
        i_opcode = op;
        c0       = cyc;
        tick(1);
        i_trig   = 1'b0;
        i_opcode = 4'd0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = d_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk);
            if (d_cnt != d0) break;
        end
        #1;
        check(tag, 32'(d_cnt - d0), 32'd1);
    endtask

    initial begin
        int k0, i0, w0, d0, e0, l0;

        // Reset state
        tick(3);
        check("rst_outputs", 32'(all_outs), 32'd0);
        i_rst = 1'b0;
        tick(2);
        check("idle_outputs", 32'(all_outs), 32'd0);

        // Single-tile LINEAR layer with exact cycle timing
        push_layer(4'd3);
        trig_op(4'd3);
        check("t1_busy", 32'(o_busy), 32'd1);
        wait_done("t1_done", 400);
        check("t1_idle_busy", 32'(o_busy), 32'd0);
        check("t1_drain", 32'(sb_q.size()), 32'd0);
        check("t1_load_cycle", 32'(t_load - c0 + 1), 32'd148);
        check("t1_owd_cycle", 32'(t_owd - c0 + 1), 32'd151);
        check("t1_valid_cycle", 32'(t_v0 - c0 + 1), 32'd152);
        check("t1_done_cycle", 32'(t_done - c0 + 1), 32'd154);
        check("t1_img_span", 32'(t_load - t_img0), 32'd72);

        // Illegal opcode
        e0 = e_cnt;
        push_ev(EV_E, 10'd0);
        trig_op(4'd7);
        check("err_busy0", 32'(o_busy), 32'd0);
        tick(3);
        check("err_once", 32'(e_cnt - e0), 32'd1);
        check("err_cycle", 32'(t_err - c0), 32'd1);
        check("err_busy1", 32'(o_busy), 32'd0);
        check("err_drain", 32'(sb_q.size()), 32'd0);

        // Opcode 0 after the rejected trig: full 256-tile layer
        push_layer(4'd0);
        trig_op(4'd0);
        wait_done("op0_done", 25000);
        check("op0_drain", 32'(sb_q.size()), 32'd0);

        // Opcode 2 with trigs during the layer that must be ignored
        k0 = k_cnt; i0 = i_cnt; w0 = w_cnt; d0 = d_cnt;
        push_layer(4'd2);
        trig_op(4'd2);
        tick(20);
        i_trig = 1'b1; i_opcode = 4'd9;
        tick(1);
        i_trig = 1'b0;
        tick(100);
        i_trig = 1'b1; i_opcode = 4'd0;
        tick(1);
        i_trig = 1'b0; i_opcode = 4'd0;
        wait_done("op2_done", 3000);
        tick(5);
        check("op2_ker_writes", 32'(k_cnt - k0), 32'd72);
        check("op2_img_writes", 32'(i_cnt - i0), 32'd1152);
        check("op2_out_wd", 32'(w_cnt - w0), 32'd16);
        check("op2_done_cnt", 32'(d_cnt - d0), 32'd1);
        check("op2_drain", 32'(sb_q.size()), 32'd0);

        // Host valid alternating: image phase takes twice as long
        i0 = i_cnt;
        toggle_valid = 1'b1;
        push_layer(4'd3);
        trig_op(4'd3);
        wait_done("tog_done", 800);
        toggle_valid = 1'b0;
        check("tog_img_span", 32'(t_load - t_img0), 32'd143);
        check("tog_img_writes", 32'(i_cnt - i0), 32'd72);
        check("tog_drain", 32'(sb_q.size()), 32'd0);

        // Write-back stall
        i_out_ready = 1'b0;
        push_layer(4'd3);
        trig_op(4'd3);
        for (int i = 0; i < 400; i++) begin
            if (o_valid) break;
            tick(1);
        end
        check("wb_reached", 32'(o_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("wb_hold_valid", 32'(o_valid), 32'd1);
            check("wb_hold_addr", 32'(o_out_addr), 32'd0);
            check("wb_hold_inrdy", 32'(o_in_ready), 32'd0);
            check("wb_hold_busy", 32'(o_busy), 32'd1);
            tick(1);
        end
        i_out_ready = 1'b1;
        wait_done("wb_done", 20);
        check("wb_drain", 32'(sb_q.size()), 32'd0);

        // Reset during EX of tile 5 of opcode 1
        d0 = d_cnt;
        l0 = l_cnt;
        push_head();
        for (int t = 0; t < 5; t++) push_tile(1'b1);
        push_tile(1'b0);
        trig_op(4'd1);
        for (int i = 0; i < 2000; i++) begin
            @(posedge i_clk);
            if (l_cnt - l0 == 6) break;
        end
        #1;
        check("abort_reached", 32'(l_cnt - l0), 32'd6);
        i_rst = 1'b1;
        #1;
        check("abort_outputs", 32'(all_outs), 32'd0);
        check("abort_drain", 32'(sb_q.size()), 32'd0);
        tick(3);
        check("abort_no_done", 32'(d_cnt - d0), 32'd0);
        check("abort_outputs_held", 32'(all_outs), 32'd0);
        i_rst = 1'b0;
        tick(2);

        // Fresh layer after the abort starts from kernel load
        push_layer(4'd3);
        trig_op(4'd3);
        wait_done("restart_done", 400);
        check("restart_load_cycle", 32'(t_load - c0 + 1), 32'd148);
        check("restart_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
